// File: rtl/maria_bus_arbiter_if.sv
// rtl/maria_bus_arbiter_if.sv - DMA/CPU handshake bundle for the Maria bus arbiter (dma_cycles present under DMA_STEAL_COUNT_EN)
interface maria_bus_arbiter_if;
    logic       maria_en;
    logic       dma_req;
    logic       dma_done;
    logic       wsync;
    logic       lrc;
    logic       halt_n;
    logic       ready;
    logic       grant;
    logic       drive_AB;
    logic       busy;
`ifdef DMA_STEAL_COUNT_EN
    logic [9:0] dma_cycles;

    modport master (
        output maria_en, dma_req, dma_done, wsync, lrc,
        input  halt_n, ready, grant, drive_AB, busy, dma_cycles
    );
    modport slave (
        input  maria_en, dma_req, dma_done, wsync, lrc,
        output halt_n, ready, grant, drive_AB, busy, dma_cycles
    );
`else
    modport master (
        output maria_en, dma_req, dma_done, wsync, lrc,
        input  halt_n, ready, grant, drive_AB, busy
    );
    modport slave (
        input  maria_en, dma_req, dma_done, wsync, lrc,
        output halt_n, ready, grant, drive_AB, busy
    );
`endif
endinterface

// File: rtl/maria_bus_arbiter.sv
// rtl/maria_bus_arbiter.sv - CPU halt / DMA grant scheduler with WSYNC ready stall; DMA_STEAL_COUNT_EN adds dma_cycles
module maria_bus_arbiter #(
    parameter int HALT_SETTLE  = 1,
    parameter int RELEASE_MCLK = 2
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 mclk0,
    input  logic                 pclk0,
    input  logic                 pclk1,
    maria_bus_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        HALT_REQ,
        SETTLE,
        GRANT,
        RELEASE
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] settle_cnt_q, settle_cnt_d;
    logic [2:0] rel_cnt_q, rel_cnt_d;
    logic       wsync_pend_q, wsync_pend_d;
    logic       pclk_low_q, pclk_low_d;
    logic       ready_q, ready_d;
    logic       halt_n_q, halt_n_d;
    logic       grant_q, grant_d;
    logic       drive_ab_q, drive_ab_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        rel_cnt_d    = rel_cnt_q;
        wsync_pend_d = wsync_pend_q;
        pclk_low_d   = pclk_low_q;
        ready_d      = ready_q;
        drive_ab_d   = drive_ab_q;

        if (ce) begin
            if (pclk1)
                pclk_low_d = 1'b1;
            else if (pclk0)
                pclk_low_d = 1'b0;

            if (bus.lrc)
                wsync_pend_d = 1'b0;
            else if (bus.wsync)
                wsync_pend_d = 1'b1;

            // ready only moves while phi is low so the CPU never sees it change mid-cycle
            if (pclk_low_q)
                ready_d = ~wsync_pend_d;

            if (!bus.maria_en) begin
                state_d      = IDLE;
                settle_cnt_d = 2'd0;
                rel_cnt_d    = 3'd0;
                wsync_pend_d = 1'b0;
                ready_d      = 1'b1;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.dma_req)
                            state_d = HALT_REQ;
                    end
                    HALT_REQ: begin
                        if (!bus.dma_req) begin
                            state_d   = RELEASE;
                            rel_cnt_d = 3'd1;
                        end else if (pclk1) begin
                            state_d      = SETTLE;
                            settle_cnt_d = 2'(HALT_SETTLE - 1);
                        end
                    end
                    SETTLE: begin
                        if (!bus.dma_req) begin
                            state_d   = RELEASE;
                            rel_cnt_d = 3'd1;
                        end else if (pclk1) begin
                            if (settle_cnt_q == 2'd0)
                                state_d = GRANT;
                            else
                                settle_cnt_d = settle_cnt_q - 2'd1;
                        end
                    end
                    GRANT: begin
                        if (bus.dma_done) begin
                            state_d   = RELEASE;
                            rel_cnt_d = 3'(RELEASE_MCLK);
                        end
                    end
                    RELEASE: begin
                        // the final mclk0 and the returning pclk0 must be separate strobes
                        if (rel_cnt_q != 3'd0) begin
                            if (mclk0)
                                rel_cnt_d = rel_cnt_q - 3'd1;
                        end else if (pclk0) begin
                            state_d = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
            drive_ab_d = (state_d == GRANT) && bus.maria_en;
        end
    end

    assign halt_n_d = (state_d == IDLE);
    assign grant_d  = (state_d == GRANT);
    assign busy_d   = (state_d != IDLE);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= IDLE;
            settle_cnt_q <= 2'd0;
            rel_cnt_q    <= 3'd0;
            wsync_pend_q <= 1'b0;
            pclk_low_q   <= 1'b0;
            ready_q      <= 1'b1;
            halt_n_q     <= 1'b1;
            grant_q      <= 1'b0;
            drive_ab_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            rel_cnt_q    <= rel_cnt_d;
            wsync_pend_q <= wsync_pend_d;
            pclk_low_q   <= pclk_low_d;
            ready_q      <= ready_d;
            halt_n_q     <= halt_n_d;
            grant_q      <= grant_d;
            drive_ab_q   <= drive_ab_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.halt_n   = halt_n_q;
    assign bus.ready    = ready_q | (ce & bus.lrc & pclk_low_q);
    assign bus.grant    = grant_q;
    assign bus.drive_AB = drive_ab_q;
    assign bus.busy     = busy_q;

`ifdef DMA_STEAL_COUNT_EN
    logic [9:0] steal_cnt_q, steal_cnt_d;
    logic [9:0] dma_cycles_q, dma_cycles_d;

    always_comb begin
        steal_cnt_d  = steal_cnt_q;
        dma_cycles_d = dma_cycles_q;
        if (ce) begin
            if (bus.lrc) begin
                dma_cycles_d = steal_cnt_q;
                steal_cnt_d  = 10'd0;
            end else if (mclk0 && grant_q && steal_cnt_q != 10'h3FF) begin
                steal_cnt_d = steal_cnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            steal_cnt_q  <= 10'd0;
            dma_cycles_q <= 10'd0;
        end else begin
            steal_cnt_q  <= steal_cnt_d;
            dma_cycles_q <= dma_cycles_d;
        end
    end

    assign bus.dma_cycles = dma_cycles_q;
`endif

    a_grant_halted: assert property (@(posedge clk_sys) disable iff (reset) grant_q |-> !halt_n_q);

endmodule

// File: tb/tb_maria_bus_arbiter.sv
// tb/tb_maria_bus_arbiter.sv - directed-vector bench for maria_bus_arbiter
module tb_maria_bus_arbiter;

    logic clk_sys = 1'b0;
    logic reset;
    logic ce;
    logic mclk0;
    logic pclk0;
    logic pclk1;

    int total = 0;
    int bad   = 0;

    maria_bus_arbiter_if bif ();

    maria_bus_arbiter #(
        .HALT_SETTLE  (1),
        .RELEASE_MCLK (2)
    ) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce      (ce),
        .mclk0   (mclk0),
        .pclk0   (pclk0),
        .pclk1   (pclk1),
        .bus     (bif.slave)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // one clock with the given strobes; one-shot inputs are cleared afterwards
    task automatic cyc(input logic m0, input logic p0, input logic p1);
        mclk0 = m0;
        pclk0 = p0;
        pclk1 = p1;
        @(posedge clk_sys);
        #1;
        mclk0        = 1'b0;
        pclk0        = 1'b0;
        pclk1        = 1'b0;
        bif.dma_done = 1'b0;
        bif.wsync    = 1'b0;
        bif.lrc      = 1'b0;
    endtask

    task automatic reach_grant();
        bif.dma_req = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
    endtask

    initial begin
        reset        = 1'b1;
        ce           = 1'b1;
        mclk0        = 1'b0;
        pclk0        = 1'b0;
        pclk1        = 1'b0;
        bif.maria_en = 1'b1;
        bif.dma_req  = 1'b0;
        bif.dma_done = 1'b0;
        bif.wsync    = 1'b0;
        bif.lrc      = 1'b0;
        repeat (3) cyc(0, 0, 0);
        check("rst_halt_n", bif.halt_n, 1);
        check("rst_ready", bif.ready, 1);
        check("rst_grant", bif.grant, 0);
        check("rst_busy", bif.busy, 0);
        check("rst_drive", bif.drive_AB, 0);
`ifdef DMA_STEAL_COUNT_EN
        check("rst_dma_cycles", bif.dma_cycles, 0);
`endif
        reset = 1'b0;

        for (int i = 0; i < 100; i++) cyc(i % 2 == 0, i % 8 == 7, i % 8 == 3);
        check("idle_halt_n", bif.halt_n, 1);
        check("idle_ready", bif.ready, 1);
        check("idle_grant", bif.grant, 0);
        check("idle_busy", bif.busy, 0);

        // ce low freezes everything
        bif.dma_req = 1'b1;
        ce = 1'b0;
        cyc(0, 0, 1);
        check("ce_hold_halt_n", bif.halt_n, 1);
        ce = 1'b1;

        // full grant cycle
        cyc(0, 0, 0);
        check("req_halt_n", bif.halt_n, 0);
        check("req_busy", bif.busy, 1);
        cyc(0, 0, 1);
        check("settle_grant", bif.grant, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("settle2_grant", bif.grant, 0);
        cyc(0, 0, 1);
        check("grant_on", bif.grant, 1);
        check("grant_drive", bif.drive_AB, 1);
        check("grant_halt_n", bif.halt_n, 0);
        cyc(1, 0, 0);
        check("grant_hold", bif.grant, 1);
        bif.dma_done = 1'b1;
        cyc(0, 0, 0);
        check("rel_grant", bif.grant, 0);
        check("rel_drive", bif.drive_AB, 0);
        check("rel_halt_n", bif.halt_n, 0);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        check("rel_early_pclk0", bif.halt_n, 0);
        cyc(1, 0, 0);
        check("rel_cnt0_halt_n", bif.halt_n, 0);
        cyc(0, 1, 0);
        check("rel_done_halt_n", bif.halt_n, 1);
        check("rel_done_busy", bif.busy, 0);
        // dma_req still high: one-cycle halt_n pulse then re-halt
        cyc(0, 0, 0);
        check("rehalt_halt_n", bif.halt_n, 0);

        // abort before the first pclk1
        bif.dma_req = 1'b0;
        cyc(0, 0, 0);
        check("abort_grant", bif.grant, 0);
        check("abort_halt_n", bif.halt_n, 0);
        cyc(1, 0, 0);
        check("abort_mclk_halt_n", bif.halt_n, 0);
        cyc(0, 1, 0);
        check("abort_done_halt_n", bif.halt_n, 1);
        check("abort_done_grant", bif.grant, 0);

        // maria_en drop during grant
        reach_grant();
        check("en_grant_on", bif.grant, 1);
        bif.maria_en = 1'b0;
        cyc(0, 0, 0);
        check("en_off_grant", bif.grant, 0);
        check("en_off_drive", bif.drive_AB, 0);
        check("en_off_halt_n", bif.halt_n, 1);
        check("en_off_busy", bif.busy, 0);
        cyc(0, 0, 0);
        check("en_off_stay", bif.halt_n, 1);
        bif.dma_req  = 1'b0;
        bif.maria_en = 1'b1;

        // wsync stall
        cyc(0, 1, 0);
        bif.wsync = 1'b1;
        cyc(0, 0, 0);
        check("ws_high_ready", bif.ready, 1);
        cyc(0, 0, 1);
        check("ws_pclk1_ready", bif.ready, 1);
        cyc(0, 0, 0);
        check("ws_low_ready", bif.ready, 0);
        for (int i = 0; i < 500; i++) cyc(i % 2 == 0, i % 8 == 7, i % 8 == 3);
        check("ws_hold_ready", bif.ready, 0);
        bif.lrc = 1'b1;
        #1;
        check("lrc_comb_ready", bif.ready, 1);
        cyc(0, 0, 0);
        check("lrc_reg_ready", bif.ready, 1);
        bif.wsync = 1'b1;
        bif.lrc   = 1'b1;
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("ws_lrc_same_ready", bif.ready, 1);

`ifdef DMA_STEAL_COUNT_EN
        reach_grant();
        repeat (37) cyc(1, 0, 0);
        bif.dma_done = 1'b1;
        bif.dma_req  = 1'b0;
        cyc(0, 0, 0);
        bif.lrc = 1'b1;
        cyc(0, 0, 0);
        check("steal_37", bif.dma_cycles, 37);
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        reach_grant();
        repeat (1500) cyc(1, 0, 0);
        bif.dma_req  = 1'b0;
        bif.maria_en = 1'b0;
        cyc(0, 0, 0);
        bif.maria_en = 1'b1;
        bif.lrc      = 1'b1;
        cyc(0, 0, 0);
        check("steal_sat", bif.dma_cycles, 1023);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/maria_bus_arbiter.md
Name: maria_bus_arbiter

Overview:
Schedules ownership of the shared system address/data bus between the SALLY CPU and Maria's DMA engine. It converts a DMA request into a correctly phased CPU halt, grants the bus to DMA only once the CPU is parked, and returns the bus on a phi-clock boundary. It also owns the WSYNC ready-stall so that halt and ready never conflict. It sits between the DMA sequencer and the CPU halt/ready pins, inside the Maria top level.

Parameters:
HALT_SETTLE, 1, number of pclk1 edges with halt_n low before grant may assert (1..3)
RELEASE_MCLK, 2, mclk0 pulses between DMA release and halt_n returning high (1..7)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high
ce  in  1  master-oscillator clock enable; all state advances only when ce=1
mclk0  in  1  Maria phase-0 strobe, one clk_sys wide
pclk0  in  1  CPU phi rising strobe
pclk1  in  1  CPU phi falling strobe
maria_en  in  1  Maria enable; low forces CPU ownership
dma_req  in  1  level; DMA wants the bus
dma_done  in  1  one-strobe; DMA finished its burst
wsync  in  1  one-strobe; CPU wrote WSYNC
lrc  in  1  one-strobe; line-ram swap / start of line
halt_n  out  1  CPU halt pin, active-low
ready  out  1  CPU ready pin
grant  out  1  DMA owns bus
drive_AB  out  1  Maria drives address bus (grant and maria_en)
busy  out  1  state != IDLE

Behaviour:
- Reset values: state=IDLE, halt_n=1, ready=1, grant=0, drive_AB=0, busy=0, all counters 0.
- All transitions qualified by ce; strobes sampled only when ce=1.
- States: IDLE, HALT_REQ, SETTLE, GRANT, RELEASE.
- IDLE: dma_req=1 and maria_en=1 -> HALT_REQ; halt_n drops on the same transition cycle.
- HALT_REQ: wait for next pclk1 strobe (CPU finishes current cycle) -> SETTLE; settle_cnt loaded with HALT_SETTLE-1.
- SETTLE: each pclk1 decrements settle_cnt; at 0 plus pclk1 -> GRANT; grant=1 from next cycle.
- GRANT: grant=1, halt_n=0. dma_done -> RELEASE; grant=0 the next cycle; rel_cnt=RELEASE_MCLK.
- RELEASE: each mclk0 decrements rel_cnt; at 0 wait for pclk0 -> IDLE; halt_n=1 on entry to IDLE.
- dma_done outside GRANT is ignored. dma_req deasserted in HALT_REQ/SETTLE -> RELEASE with rel_cnt=1 (abort, no grant issued).
- dma_req high on entry to IDLE from RELEASE -> re-enter HALT_REQ next ce cycle; halt_n pulses high for exactly one ce cycle.
- maria_en=0 in any state: next ce cycle state=IDLE, halt_n=1, grant=0, ready=1, wsync_pend=0.
- Ready: wsync sets wsync_pend; lrc clears it. Same-cycle wsync and lrc: lrc wins (pend=0). ready = ~wsync_pend, updated only while pclk low (between pclk1 and pclk0), otherwise holds; lrc also forces ready=1 combinationally while pclk is low.
- halt_n and ready independent; a wsync arriving during GRANT is latched and takes effect after release.
- Latency: dma_req rise to grant = 1 + (pclk1 edges: 1 + HALT_SETTLE) minimum; grant never asserts while halt_n=1.
- Invariant: grant=1 implies halt_n=0; checked by assertion.

Optional Feature:
DMA_STEAL_COUNT_EN: adds output dma_cycles[9:0]. An internal 10-bit counter increments on each mclk0 while grant=1, saturates at 1023, and is copied to dma_cycles and cleared on lrc; dma_cycles resets to 0. Without the macro, the port and counter are absent.

Test Plan:
- Reset, then idle 100 cycles -> halt_n=1, ready=1, grant=0, busy=0.
- dma_req=1 with HALT_SETTLE=1 -> halt_n=0 same cycle; grant=1 one cycle after the second pclk1; dma_done -> grant=0 next cycle; halt_n=1 after 2 mclk0 plus the next pclk0.
- dma_req dropped before the first pclk1 -> grant never 1; halt_n returns 1 after 1 mclk0 plus pclk0.
- wsync at cycle N, lrc at N+500 -> ready=0 from the first pclk-low window after N until lrc; wsync and lrc in the same cycle -> ready stays 1.
- maria_en dropped during GRANT -> next ce cycle grant=0, drive_AB=0, halt_n=1, state IDLE.
- DMA_STEAL_COUNT_EN defined, grant held for 37 mclk0 in a line -> dma_cycles=37 after lrc; 1500 mclk0 -> dma_cycles=1023.
